ws281x_tx: RTL and testbench

WS281X_TX -- requirements
Module: ws281x_tx

---
 rtl/ws281x_pkg.sv | 39 +++
 rtl/ws281x_pixram.sv | 25 ++
 rtl/ws281x_tx.sv | 197 +++++++++++++++++++
 tb/tb_ws281x_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ws281x_pkg.sv
// Shared timing constants, state encoding and small lookup helpers for the
// WS281x serial transmitter.
package ws281x_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_t;

    // Bit timings in clk50 cycles for 800 kHz (WS2812B) and 400 kHz (WS2811)
    localparam int T0H_800  = 20;
    localparam int T1H_800  = 40;
    localparam int PER_800  = 63;
    localparam int T0H_400  = 25;
    localparam int T1H_400  = 60;
    localparam int PER_400  = 125;

    localparam int BPP_RGB  = 24;
    localparam int BPP_RGBW = 32;

    localparam int TIM_W    = 8;

    function automatic logic [TIM_W-1:0] high_len(input logic mode, input logic bit_val);
        if (mode) return bit_val ? TIM_W'(T1H_400) : TIM_W'(T0H_400);
        return bit_val ? TIM_W'(T1H_800) : TIM_W'(T0H_800);
    endfunction

    function automatic logic [TIM_W-1:0] period_len(input logic mode);
        return mode ? TIM_W'(PER_400) : TIM_W'(PER_800);
    endfunction

    function automatic logic [5:0] bits_per_px(input logic rgbw);
        return rgbw ? 6'(BPP_RGBW) : 6'(BPP_RGB);
    endfunction

endpackage

// File: rtl/ws281x_pixram.sv
// Two-bank pixel store: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module ws281x_pixram #(
    parameter int AW = 9
) (
    input  logic          clk50,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk50) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ws281x_tx.sv
// WS281x LED strip transmitter: streams a bank of stored pixels as
// pulse-width encoded bits, then holds the line low for the latch interval.
module ws281x_tx
    import ws281x_pkg::*;
#(
    parameter int PIXEL_AW     = 8,
    parameter int LATCH_CYCLES = 14000
) (
    input  logic                clk50,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [PIXEL_AW:0]   wr_addr,
    input  logic [31:0]         wr_data,
    input  logic                start,
    input  logic                bank,
    input  logic [PIXEL_AW:0]   count,
    input  logic                mode,
    input  logic                rgbw,
    output logic                busy,
    output logic                done,
    output logic                tx_out
);

    localparam int CW = PIXEL_AW + 1;
    localparam int LW = $clog2(LATCH_CYCLES + 1);

    state_t            state_q, state_d;
    logic [TIM_W-1:0]  tim_q, tim_d;
    logic [5:0]        bit_q, bit_d;
    logic [CW-1:0]     px_q, px_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [31:0]       pix_q, pix_d;
    logic              bank_q, bank_d;
    logic              mode_q, mode_d;
    logic              rgbw_q, rgbw_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              rd_en;
    logic [PIXEL_AW:0] rd_addr;
    logic [31:0]       rd_data;

    logic [5:0]        bpp;
    logic [4:0]        bit_idx;
    logic              cur_bit;
    logic [TIM_W-1:0]  th_len;
    logic [TIM_W-1:0]  per_len;
    logic              last_bit;
    logic              last_px;
    logic              hi_end;
    logic              bit_end;
    logic              lat_end;
    logic              px_first;

    ws281x_pixram #(.AW(PIXEL_AW + 1)) u_ram (
        .clk50 (clk50),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign bpp      = bits_per_px(rgbw_q);
    assign bit_idx  = 5'(bpp - 6'd1 - bit_q);
    assign cur_bit  = pix_q[bit_idx];
    assign th_len   = high_len(mode_q, cur_bit);
    assign per_len  = period_len(mode_q);
    assign last_bit = (bit_q == bpp - 6'd1);
    assign last_px  = (px_q == cnt_q - CW'(1));
    assign hi_end   = (state_q == ST_HIGH) && (tim_q == th_len - TIM_W'(1));
    assign bit_end  = (state_q == ST_LOW) && (tim_q == per_len - TIM_W'(1));
    assign lat_end  = (state_q == ST_LATCH) && (lat_q == LW'(LATCH_CYCLES - 1));
    // The pixel word is only needed once the high phase nears its end, so it
    // is latched on the first cycle of a pixel, when the read data is valid.
    assign px_first = (state_q == ST_HIGH) && (tim_q == '0) && (bit_q == '0);

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  state_d = (cnt_q == '0) ? ST_IDLE : ST_HIGH;
            ST_HIGH:  if (hi_end) state_d = ST_LOW;
            ST_LOW:   if (bit_end) state_d = (last_bit && last_px) ? ST_LATCH : ST_HIGH;
            ST_LATCH: if (lat_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_out = (state_q == ST_HIGH);
        busy   = busy_q;
        done   = done_q;
    end

    // Next pixel is fetched at the start of the current pixel's last bit.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = {bank_q, PIXEL_AW'(0)};
        if (state_q == ST_LOAD) begin
            rd_en = 1'b1;
        end else if (state_q == ST_HIGH && tim_q == '0 && last_bit && !last_px) begin
            rd_en   = 1'b1;
            rd_addr = {bank_q, px_q[PIXEL_AW-1:0] + PIXEL_AW'(1)};
        end
    end

    always_comb begin
        tim_d  = tim_q;
        bit_d  = bit_q;
        px_d   = px_q;
        cnt_d  = cnt_q;
        lat_d  = lat_q;
        pix_d  = pix_q;
        bank_d = bank_q;
        mode_d = mode_q;
        rgbw_d = rgbw_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (state_q == ST_IDLE && start) begin
            bank_d = bank;
            cnt_d  = count;
            mode_d = mode;
            rgbw_d = rgbw;
            tim_d  = '0;
            bit_d  = '0;
            px_d   = '0;
            lat_d  = '0;
            busy_d = 1'b1;
        end

        if (state_q == ST_LOAD && cnt_q == '0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (px_first) pix_d = rd_data;

        if (state_q == ST_HIGH || state_q == ST_LOW) begin
            tim_d = tim_q + TIM_W'(1);
            if (bit_end) begin
                tim_d = '0;
                if (last_bit) begin
                    bit_d = '0;
                    px_d  = px_q + CW'(1);
                end else begin
                    bit_d = bit_q + 6'd1;
                end
            end
        end

        if (state_q == ST_LATCH) begin
            lat_d = lat_q + LW'(1);
            if (lat_end) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            tim_q  <= '0;
            bit_q  <= '0;
            px_q   <= '0;
            cnt_q  <= '0;
            lat_q  <= '0;
            pix_q  <= '0;
            bank_q <= 1'b0;
            mode_q <= 1'b0;
            rgbw_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tim_q  <= tim_d;
            bit_q  <= bit_d;
            px_q   <= px_d;
            cnt_q  <= cnt_d;
            lat_q  <= lat_d;
            pix_q  <= pix_d;
            bank_q <= bank_d;
            mode_q <= mode_d;
            rgbw_q <= rgbw_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_ws281x_tx.sv
// Directed bench for ws281x_tx: expected pulse widths are queued per pixel
// when a frame is started and checked as the serial line produces them.
module tb_ws281x_tx;

    localparam int AW  = 8;
    localparam int LAT = 14000;

    logic          clk50 = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW:0]   wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          start = 1'b0;
    logic          bank = 1'b0;
    logic [AW:0]   count = '0;
    logic          mode = 1'b0;
    logic          rgbw = 1'b0;
    logic          busy, done, tx_out;

    int checks = 0;
    int errors = 0;
    int exp_hi[$];
    int exp_per = 63;
    int exp_tail = 0;
    int done_cnt = 0;

    logic [31:0] b1_px [6] = '{32'h0011_2233, 32'h0044_5566, 32'h0077_8899,
                               32'h00AA_BBCC, 32'h00DD_EEFF, 32'h0000_00F0};
    localparam logic [31:0] B1_PX5_NEW = 32'h00E7_813C;
    localparam logic [31:0] B0_PX1     = 32'hA5C3_0F96;
    localparam logic [31:0] B0_PX2     = 32'h1234_5678;

    ws281x_tx #(.PIXEL_AW(AW), .LATCH_CYCLES(LAT)) dut (
        .clk50   (clk50),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .bank    (bank),
        .count   (count),
        .mode    (mode),
        .rgbw    (rgbw),
        .busy    (busy),
        .done    (done),
        .tx_out  (tx_out)
    );

    always #10 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_px(input logic [31:0] d, input bit w, input bit m);
        int nb = w ? 32 : 24;
        int th = 0;
        for (int i = nb - 1; i >= 0; i--) begin
            th = d[i] ? (m ? 60 : 40) : (m ? 25 : 20);
            exp_hi.push_back(th);
        end
        exp_tail = (m ? 125 : 63) - th + LAT + 1;
    endtask

    task automatic wr(input logic [AW:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk50); #1;
        wr_en = 1'b0;
    endtask

    task automatic go(input logic b, input logic [AW:0] n, input logic m, input logic w);
        start = 1'b1; bank = b; count = n; mode = m; rgbw = w;
        @(posedge clk50); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        int busy_lo = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk50);
            n++;
            if (done !== 1'b1 && busy !== 1'b1) busy_lo++;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_busy_held"}, busy_lo, 0);
        chk({tag, "_busy_fall"}, busy, 0);
    endtask

    // Line monitor: measures high widths, rise-to-rise periods, latch tail.
    initial begin
        int hi = 0;
        int lo = 0;
        int per = 0;
        bit seen = 1'b0;
        logic prev = 1'b0;
        forever begin
            @(negedge clk50);
            if (!rst_n) begin
                hi = 0; lo = 0; per = 0; seen = 1'b0; prev = 1'b0;
            end else begin
                if (tx_out === 1'b1 && prev === 1'b0) begin
                    if (seen) chk("period", per, exp_per);
                    per = 0; hi = 0; seen = 1'b1;
                end
                if (tx_out === 1'b0 && prev === 1'b1) begin
                    if (exp_hi.size() > 0) chk("high_len", hi, exp_hi.pop_front());
                    else chk("extra_bit", 1, 0);
                    lo = 0;
                end
                if (tx_out === 1'b1) hi++; else lo++;
                per++;
                if (done === 1'b1) begin
                    done_cnt++;
                    if (seen) chk("latch_tail", lo, exp_tail);
                    seen = 1'b0;
                end
                prev = tx_out;
            end
        end
    end

    initial begin
        int d0;
        int n;

        repeat (3) @(posedge clk50);
        @(negedge clk50);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx", tx_out, 0);
        @(posedge clk50); #1;
        rst_n = 1'b1;

        wr({1'b0, 8'd0}, 32'h00FF_0000);
        wr({1'b0, 8'd1}, B0_PX1);
        wr({1'b0, 8'd2}, B0_PX2);
        for (int i = 0; i < 6; i++) wr({1'b1, 8'(i)}, b1_px[i]);

        // Frame 1: single GRB pixel, plus a start request while busy
        exp_per = 63;
        push_px(32'h00FF_0000, 1'b0, 1'b0);
        d0 = done_cnt;
        go(1'b0, 9'd1, 1'b0, 1'b0);
        repeat (9) @(posedge clk50); #1;
        go(1'b1, 9'd5, 1'b1, 1'b1);
        chk("f1_busy_after_2nd", busy, 1);
        wait_done(20000, "f1");
        repeat (100) @(negedge clk50);
        chk("f1_one_done", done_cnt - d0, 1);
        chk("f1_bits_left", exp_hi.size(), 0);
        chk("f1_idle_tx", tx_out, 0);

        // Frame 2: three RGBW pixels at 400 kHz; bank 1 px5 rewritten meanwhile
        exp_per = 125;
        push_px(32'h00FF_0000, 1'b1, 1'b1);
        push_px(B0_PX1, 1'b1, 1'b1);
        push_px(B0_PX2, 1'b1, 1'b1);
        @(posedge clk50); #1;
        go(1'b0, 9'd3, 1'b1, 1'b1);
        repeat (100) @(posedge clk50); #1;
        wr({1'b1, 8'd5}, B1_PX5_NEW);
        wait_done(40000, "f2");
        chk("f2_bits_left", exp_hi.size(), 0);

        // Empty frame: done two cycles after start, line stays low
        @(posedge clk50); #1;
        d0 = done_cnt;
        go(1'b0, 9'd0, 1'b0, 1'b0);
        @(negedge clk50);
        chk("z_done_c1", done, 0);
        chk("z_busy_c1", busy, 1);
        @(negedge clk50);
        chk("z_done_c2", done, 1);
        chk("z_busy_c2", busy, 0);
        chk("z_tx_c2", tx_out, 0);
        @(negedge clk50);
        chk("z_done_c3", done, 0);
        chk("z_one_done", done_cnt - d0, 1);

        // Bank 1 frame shows new px5; reset lands in the final bit's high phase
        exp_per = 63;
        for (int i = 0; i < 5; i++) push_px(b1_px[i], 1'b0, 1'b0);
        push_px(B1_PX5_NEW, 1'b0, 1'b0);
        void'(exp_hi.pop_back());
        @(posedge clk50); #1;
        go(1'b1, 9'd6, 1'b0, 1'b0);
        n = 0;
        while (exp_hi.size() != 0 && n < 20000) begin @(negedge clk50); n++; end
        chk("b1_drained", exp_hi.size(), 0);
        n = 0;
        while (tx_out !== 1'b1 && n < 200) begin @(negedge clk50); n++; end
        chk("b1_last_high", tx_out, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_tx", tx_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        exp_hi.delete();
        repeat (3) @(posedge clk50); #1;
        rst_n = 1'b1;

        // Normal frame after the abort
        wr({1'b0, 8'd0}, 32'h0096_0001);
        exp_per = 63;
        push_px(32'h0096_0001, 1'b0, 1'b0);
        go(1'b0, 9'd1, 1'b0, 1'b0);
        wait_done(20000, "f4");
        chk("f4_bits_left", exp_hi.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
